tick_rate_checker: RTL

- Consumer side of the 100 MHz → 1 kHz divided clock. Samples a slow, asynchronous clock (clk_k class signal) in the 100 MHz domain.
- Measures its period in fast-clock cycles and reports each measurement with a one-cycle valid pulse.
- Declares lock/loss of lock against an expected period, and flags a timeout when edges stop arriving.
- Sits between the divider output and the RTC controller timing logic as a health monitor and tick-enable source.

---
 rtl/tick_rate_pkg.sv | 34 +++
 rtl/tick_rate_checker_if.sv | 39 +++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/tick_rate_checker.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tick_rate_pkg.sv
// Shared types and defaults for the slow-clock rate checker (100 MHz sampling a 1 kHz tick).
package tick_rate_pkg;

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2
    } state_e;

    localparam int unsigned DefExpected = 100000;
    localparam int unsigned DefTol      = 100;
    localparam int unsigned DefLockCnt  = 4;
    localparam int unsigned DefTimeout  = 200000;
    localparam int unsigned DefW        = 18;

    typedef struct packed {
        int lo;
        int hi;
    } window_t;

    // Lower bound may go negative; upper bound is clipped to the largest W-bit value.
    function automatic window_t tol_window(input int center, input int tol, input int w);
        window_t win;
        int      top;
        top    = (1 << w) - 1;
        win.lo = center - tol;
        win.hi = center + tol;
        if (win.hi > top) begin
            win.hi = top;
        end
        return win;
    endfunction

endpackage

// File: rtl/tick_rate_checker_if.sv
// Signal bundle between the slow-clock source and the rate checker.
// With TICK_DUTY_MEAS_EN defined it also carries high_time and duty_ok.
interface tick_rate_checker_if
    import tick_rate_pkg::*;
#(
    parameter int unsigned W = DefW
);
    logic         clk_in;
    logic         tick;
    logic [W-1:0] period;
    logic         period_vld;
    logic         in_tol;
    logic         locked;
    logic         timeout;
`ifdef TICK_DUTY_MEAS_EN
    logic [W-1:0] high_time;
    logic         duty_ok;

    modport master (
        output clk_in,
        input  tick, period, period_vld, in_tol, locked, timeout, high_time, duty_ok
    );

    modport slave (
        input  clk_in,
        output tick, period, period_vld, in_tol, locked, timeout, high_time, duty_ok
    );
`else
    modport master (
        output clk_in,
        input  tick, period, period_vld, in_tol, locked, timeout
    );

    modport slave (
        input  clk_in,
        output tick, period, period_vld, in_tol, locked, timeout
    );
`endif
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a slow asynchronous input with registered one-cycle rise/fall pulses.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);
    logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
            fall_q  <= ~sync2_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/tick_rate_checker.sv
// Measures the period of a slow asynchronous clock, tracks lock against EXPECTED+/-TOL and
// flags loss of edges. Define TICK_DUTY_MEAS_EN to add high-time (duty) measurement.
module tick_rate_checker
    import tick_rate_pkg::*;
#(
    parameter int unsigned EXPECTED = DefExpected,
    parameter int unsigned TOL      = DefTol,
    parameter int unsigned LOCK_CNT = DefLockCnt,
    parameter int unsigned TIMEOUT  = DefTimeout,
    parameter int unsigned W        = DefW
) (
    input logic                clk_i,
    input logic                rst_ni,
    tick_rate_checker_if.slave bus
);
    localparam int unsigned GW         = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam window_t     PerWin     = tol_window(int'(EXPECTED), int'(TOL), int'(W));
    localparam int          PerLoI     = PerWin.lo;
    localparam int          PerHiI     = PerWin.hi;
    localparam int unsigned TimeoutM1I = TIMEOUT - 1;
    localparam int unsigned LockM1I    = LOCK_CNT - 1;

    localparam logic signed [W:0]  PerLo     = PerLoI[W:0];
    localparam logic signed [W:0]  PerHi     = PerHiI[W:0];
    localparam logic [W-1:0]       TimeoutM1 = TimeoutM1I[W-1:0];
    localparam logic [GW-1:0]      LockM1    = LockM1I[GW-1:0];

    logic rise;
    logic fall_pulse;

    state_e          state_q;
    logic [W-1:0]    cnt_q;
    logic [GW-1:0]   good_q;
    logic [W-1:0]    period_q;
    logic            period_vld_q;
    logic            in_tol_q;
    logic            locked_q;
    logic            timeout_q;

    logic [W-1:0]    cnt_inc;
    logic signed [W:0] meas_s;
    logic            meas_ok;
    logic            timeout_hit;

    sync_edge_detect u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .async_i(bus.clk_in),
        .rise_o (rise),
        .fall_o (fall_pulse)
    );

    // cnt_inc doubles as the saturated cnt+1 measurement taken on an edge.
    always_comb begin
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + W'(1);
        meas_s      = $signed({1'b0, cnt_inc});
        meas_ok     = (meas_s >= PerLo) && (meas_s <= PerHi);
        timeout_hit = !rise && (cnt_inc == TimeoutM1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StUnlocked;
            cnt_q        <= '0;
            good_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            in_tol_q     <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            period_vld_q <= 1'b0;
            cnt_q        <= rise ? '0 : cnt_inc;
            if (rise) begin
                timeout_q <= 1'b0;
                case (state_q)
                    // First edge after reset or timeout has no reference to measure against.
                    StUnlocked: begin
                        state_q <= StAcquire;
                        good_q  <= '0;
                    end
                    StAcquire: begin
                        period_q     <= cnt_inc;
                        period_vld_q <= 1'b1;
                        in_tol_q     <= meas_ok;
                        if (!meas_ok) begin
                            good_q <= '0;
                        end else begin
                            good_q <= good_q + GW'(1);
                            if (good_q == LockM1) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    StLocked: begin
                        period_q     <= cnt_inc;
                        period_vld_q <= 1'b1;
                        in_tol_q     <= meas_ok;
                        if (!meas_ok) begin
                            state_q  <= StAcquire;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                        end
                    end
                    default: begin
                        state_q  <= StUnlocked;
                        good_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end else if (timeout_hit) begin
                state_q   <= StUnlocked;
                timeout_q <= 1'b1;
                good_q    <= '0;
                locked_q  <= 1'b0;
            end
        end
    end

    assign bus.tick       = rise;
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.in_tol     = in_tol_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;

`ifdef TICK_DUTY_MEAS_EN
    localparam window_t DutyWin = tol_window(int'(EXPECTED / 2), int'(TOL), int'(W));
    localparam int      DutyLoI = DutyWin.lo;
    localparam int      DutyHiI = DutyWin.hi;

    localparam logic signed [W:0] DutyLo = DutyLoI[W:0];
    localparam logic signed [W:0] DutyHi = DutyHiI[W:0];

    logic [W-1:0] high_time_q;
    logic         duty_ok_q;
    logic         duty_in_win;

    // cnt restarts on every rise, so at the fall it holds the high time minus one.
    always_comb begin
        duty_in_win = (meas_s >= DutyLo) && (meas_s <= DutyHi);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            high_time_q <= '0;
            duty_ok_q   <= 1'b0;
        end else if (fall_pulse) begin
            high_time_q <= cnt_inc;
            duty_ok_q   <= duty_in_win;
        end
    end

    assign bus.high_time = high_time_q;
    assign bus.duty_ok   = duty_ok_q;
`else
    logic unused_fall;
    assign unused_fall = fall_pulse;
`endif

endmodule
